// File: rtl/cpu_controller.sv
// cpu_controller -- eight-phase instruction sequencer for the 8-bit RISC CPU.
// Steps through the fetch/execute phases and drives the PC, IR, accumulator
// and memory strobes. It also holds the halt state and counts retired
// instructions.
//
// Optional feature macro: CTRL_RESUME_EN
//   When defined, a `resume` input releases the halt state. The HLT
//   instruction then completes as a no-op and is counted as retired.
//   When undefined, only reset or load leave the halt state.
//
// phase | name       | meaning
// ------+------------+-----------------------------------------------
//   0   | INST_ADDR  | PC drives the address bus
//   1   | INST_FETCH | read the instruction word
//   2   | INST_LOAD  | load the instruction register
//   3   | IDLE       | hold the IR load while the bus settles
//   4   | OP_ADDR    | advance the PC, or halt on HLT
//   5   | OP_FETCH   | read the operand for ALU-class opcodes
//   6   | ALU_OP     | skip / jump / store setup
//   7   | STORE      | accumulator load, memory write, jump commit
//
// A separate halted flag freezes the sequencer at OP_ADDR.

module cpu_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CTRL_RESUME_EN
  input  logic       resume,
`endif
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [7:0] icount
);

  localparam logic [2:0] P_INST_ADDR  = 3'd0;
  localparam logic [2:0] P_INST_FETCH = 3'd1;
  localparam logic [2:0] P_INST_LOAD  = 3'd2;
  localparam logic [2:0] P_IDLE       = 3'd3;
  localparam logic [2:0] P_OP_ADDR    = 3'd4;
  localparam logic [2:0] P_OP_FETCH   = 3'd5;
  localparam logic [2:0] P_ALU_OP     = 3'd6;
  localparam logic [2:0] P_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [7:0] icount_q, icount_d;

  logic resume_req;
  logic alu_op, is_hlt, is_skz, is_jmp, is_sto;
  logic resume_go, halt_entry;

`ifdef CTRL_RESUME_EN
  assign resume_req = resume;
`else
  assign resume_req = 1'b0;
`endif

  // Opcode classes used by the phase decode
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_jmp = (opcode == OP_JMP);
  assign is_sto = (opcode == OP_STO);

  // Resume acts in the cycle it is seen; halt entry only from an enabled OP_ADDR
  assign resume_go  = halted_q && enable && resume_req;
  assign halt_entry = !halted_q && enable && (phase_q == P_OP_ADDR) && is_hlt;

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q  <= P_INST_ADDR;
      halted_q <= 1'b0;
      icount_q <= 8'd0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  // Next-state: load > halt/resume > normal advance; disabled cycles hold
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    icount_d = icount_q;
    if (load) begin
      phase_d  = P_INST_ADDR;
      halted_d = 1'b0;
    end else if (halted_q) begin
      if (resume_go) begin
        halted_d = 1'b0;
        phase_d  = P_OP_FETCH;
      end
    end else if (enable) begin
      if (halt_entry) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_q + 3'd1;
      end
      if (phase_q == P_STORE) begin
        icount_d = icount_q + 8'd1;
      end
    end
  end

  // Strobe decode; reset and load force the fetch-address default
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (reset || load) begin
      sel = 1'b1;
    end else if (halted_q) begin
      // Resume advances the PC past the HLT in the same cycle it releases halt
      if (resume_go) begin
        inc_pc = 1'b1;
      end else begin
        halt = 1'b1;
      end
    end else if (!enable) begin
      // Only the address mux keeps following the phase while stalled
      sel = (phase_q <= P_IDLE);
    end else begin
      case (phase_q)
        P_INST_ADDR: begin
          sel = 1'b1;
        end
        P_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        P_INST_LOAD, P_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        P_OP_ADDR: begin
          if (is_hlt) begin
            halt = 1'b1;
          end else begin
            inc_pc = 1'b1;
          end
        end
        P_OP_FETCH: begin
          rd = alu_op;
        end
        P_ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        default: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
      endcase
    end
  end

  assign phase  = phase_q;
  assign icount = icount_q;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the 8-bit RISC CPU. Decodes the 3-bit opcode from the instruction register and the accumulator zero flag, and drives the phase strobes that sequence the program counter, the instruction register, the accumulator/ALU, and the memory bus. It also holds the halt state and counts retired instructions.

## Interface
- No parameters. Opcode width is fixed at 3 bits and the phase count at 8.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; highest priority.
- `enable` in 1: CPU run enable; the phase advances only when high.
- `load` in 1: program-load mode; holds the controller at phase 0.
- `opcode` in 3: IR opcode. HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- `zero` in 1: accumulator-is-zero flag.
- `resume` in 1: releases halt. Present only with `CTRL_RESUME_EN`.
- `phase` out 3: current phase, 0–7.
- `sel` out 1: address mux select (1 = PC, 0 = IR operand).
- `rd` out 1: memory read.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: PC increment.
- `ld_pc` out 1: PC load from IR operand.
- `halt` out 1: CPU halted.
- `data_e` out 1: accumulator drives the data bus.
- `ld_ac` out 1: accumulator load.
- `wr` out 1: memory write.
- `icount` out 8: retired-instruction count.

## Operation
- Registered state: `phase[2:0]`, `halted`, `icount[7:0]`. All strobes are combinational from `phase`, `opcode`, `zero`, `halted`, and `enable`.
- ALUOP is true for opcodes ADD, AND, XOR, and LDA.
- Phase decode when `enable`=1 and not halted. Strobes not listed are 0.
  - Phase 0 (INST_ADDR): `sel`.
  - Phase 1 (INST_FETCH): `sel`, `rd`.
  - Phase 2 (INST_LOAD): `sel`, `rd`, `ld_ir`.
  - Phase 3 (IDLE): `sel`, `rd`, `ld_ir`.
  - Phase 4 (OP_ADDR): `inc_pc` if opcode≠HLT. If opcode=HLT: `halt`, no `inc_pc`.
  - Phase 5 (OP_FETCH): `rd`=ALUOP.
  - Phase 6 (ALU_OP): `rd`=ALUOP; `inc_pc`=SKZ&`zero`; `ld_pc`=JMP; `data_e`=STO.
  - Phase 7 (STORE): `rd`=ALUOP; `ld_ac`=ALUOP; `inc_pc`=JMP; `ld_pc`=JMP; `data_e`=STO; `wr`=STO.
- Phase advance: `phase`<=`phase`+1 each enabled cycle. The 3-bit counter wraps 7→0.
- Halt entry: in phase 4 with opcode=HLT and `enable`=1, `halted`<=1 and `phase` stays 4.
- While halted:
  - `phase` is frozen at 4.
  - `halt`=1 and all other strobes are 0.
  - `icount` is frozen.
- Retire: `icount`<=`icount`+1 on each enabled cycle in phase 7. It wraps 255→0.
- `enable`=0 (not load, not reset):
  - `phase` and `icount` hold.
  - `rd`, `ld_ir`, `inc_pc`, `ld_pc`, `data_e`, `ld_ac`, `wr` are forced to 0.
  - `sel` follows the phase decode.
  - `halt`=`halted`.
- `load`=1 (priority over `enable` and `resume`):
  - `phase`<=0 and `halted`<=0.
  - `icount` holds.
  - All strobes 0 except `sel`=1.

## Timing
- Reset values: `phase`=0, `halted`=0, `icount`=0.
- Outputs during and just after reset: `sel`=1, all other strobes 0, `halt`=0.
- Reset asserted mid-instruction aborts the instruction. No strobe fires in the reset cycle: strobes are gated by `reset`.
- One instruction takes 8 enabled cycles. `ld_ir` is high for 2 cycles (phases 2–3). `wr` is high for 1 cycle (phase 7).
- `opcode` must be stable from phase 4 through phase 7. `zero` is sampled combinationally in phase 6.
- `enable` deasserted for N cycles stretches the current phase by N cycles. No strobe repeats or is lost.
- Simultaneous events, in priority order: `reset` > `load` > halt entry/`resume` > normal advance.

## Configuration
- `CTRL_RESUME_EN` defined: adds the `resume` port.
  - `resume`=1 while halted and `enable`=1 takes effect in that same cycle: `halted`<=0, `phase`<=5, `inc_pc`=1 for that one cycle, `halt`=0.
  - The HLT instruction then finishes as a no-op through phase 7 and is counted in `icount`.
  - `resume` has no effect when the controller is not halted.
- `CTRL_RESUME_EN` undefined: there is no `resume` port, and halt is exited only by `reset` or `load`.

## Test plan
- Reset, then ADD with `enable`=1 for 8 cycles: phases 0..7 in order; `ld_ir` high at phases 2–3; `inc_pc` at phase 4; `rd` at phases 5–7; `ld_ac` at phase 7; `icount`=1.
- SKZ with `zero`=1: `inc_pc` at phases 4 and 6. SKZ with `zero`=0: `inc_pc` at phase 4 only.
- JMP: `ld_pc` at phases 6–7 and `inc_pc` at phases 4 and 7. STO: `data_e` at phases 6–7 and `wr` at phase 7 only.
- HLT: `halt`=1 from phase 4 onward, `phase` stays 4 for 20 cycles, no strobes, `icount` unchanged. Then `load`=1 gives `phase`=0 and `halt`=0 on the next cycle.
- `enable` dropped for 3 cycles at phase 2 then restored: `phase` holds at 2 with `ld_ir`=0 for those 3 cycles, then resumes at phase 2 with `ld_ir`=1. Run 256 instructions: `icount` wraps to 0.
- With `CTRL_RESUME_EN`: HLT, then `resume` pulse gives `inc_pc`=1 for one cycle, then phases 5, 6, 7, 0; `icount` increments by 1. Reset asserted at phase 6 of STO: no `wr`, and `phase`=0 on the next cycle.
